// File: rtl/mips_harness_pkg.sv
// -----------------------------------------------------------------------------
// mips_harness_pkg
// Shared types and helpers for the mips_cpu_harness run-control block.
//   state_t           : run-control FSM states (IDLE, RESET_CPU, RUN, DONE)
//   MIPS_NOP          : word returned for fetches outside the loaded window
//   MIPS_RESET_VECTOR : default byte address of instruction word 0
//   byte_swap32()     : reverses the four bytes of a 32-bit word
// -----------------------------------------------------------------------------
package mips_harness_pkg;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_RESET_CPU = 2'd1,
      ST_RUN       = 2'd2,
      ST_DONE      = 2'd3
   } state_t;

   localparam logic [31:0] MIPS_NOP          = 32'h0000_0000;
   localparam logic [31:0] MIPS_RESET_VECTOR = 32'hBFC0_0000;

   function automatic logic [31:0] byte_swap32(input logic [31:0] w);
      return {w[7:0], w[15:8], w[23:16], w[31:24]};
   endfunction

endpackage

// File: rtl/mips_harness_imem.sv
// -----------------------------------------------------------------------------
// mips_harness_imem
// Loadable instruction memory mapped at BASE_ADDR with a combinational fetch
// port. Fetches outside the window or misaligned return MIPS_NOP; in-window
// words are optionally byte-reversed for a big-endian CPU bus.
// Ports:
//   clk      in  : clock, write port on rising edge
//   wr_en    in  : write strobe (already qualified by the caller)
//   wr_index in  : word index, $clog2(DEPTH) bits
//   wr_data  in  : word in logical (MSB-first) order
//   rd_addr  in  : CPU byte fetch address
//   rd_data  out : fetch data, zero latency
// Contents are never reset so a harness reset keeps the loaded program.
// -----------------------------------------------------------------------------
module mips_harness_imem
   import mips_harness_pkg::*;
#(
   parameter int          DEPTH      = 64,
   parameter logic [31:0] BASE_ADDR  = MIPS_RESET_VECTOR,
   parameter int          BIG_ENDIAN = 1
) (
   input  logic                     clk,
   input  logic                     wr_en,
   input  logic [$clog2(DEPTH)-1:0] wr_index,
   input  logic [31:0]              wr_data,
   input  logic [31:0]              rd_addr,
   output logic [31:0]              rd_data
);

   localparam int IW = $clog2(DEPTH);

   logic [31:0] r_mem [DEPTH];

   logic [31:0] w_offset;
   logic [31:0] w_word;
   logic        w_hit;
   logic [31:0] w_raw;

   // DEPTH is a power of two, so an IW-bit index can never exceed DEPTH-1;
   // the "discard out-of-range index" case cannot arise at this port width.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         r_mem[wr_index] <= wr_data;
      end
   end

   // The offset wraps for addresses below the base, hence the explicit
   // lower-bound check alongside the word-count check.
   assign w_offset = rd_addr - BASE_ADDR;
   assign w_word   = w_offset >> 2;
   assign w_hit    = (rd_addr >= BASE_ADDR) && (w_word < 32'(DEPTH)) &&
                     (rd_addr[1:0] == 2'b00);
   assign w_raw    = r_mem[w_word[IW-1:0]];

   always_comb begin
      rd_data = MIPS_NOP;
      if (w_hit) begin
         rd_data = (BIG_ENDIAN != 0) ? byte_swap32(w_raw) : w_raw;
      end
   end

endmodule

// File: rtl/mips_cpu_harness.sv
// -----------------------------------------------------------------------------
// mips_cpu_harness
// Run-control harness for a mips_cpu_harvard core: holds a loadable
// instruction memory, sequences the CPU reset, detects the halt condition
// (instr_address == 0 with active == 0), captures register_v0 and counts
// RUN cycles.
// Optional watchdog: define MIPS_HARNESS_TIMEOUT_EN to end a run after
// MAX_CYCLES RUN edges with timeout = 1. Without it timeout is tied 0.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   load_valid/ready  : load handshake; a word is written when both are high.
//                       load_ready is high only in IDLE and DONE.
//   load_index/data   : word index and logical-order data
//   start             : begin a run (honoured in IDLE and DONE only)
//   cpu_reset         : CPU reset, low only in RUN
//   instr_address     : CPU fetch address
//   instr_readdata    : fetch data, same cycle
//   active, register_v0 : CPU status inputs
//   done, timeout     : run finished / finished by watchdog
//   result, cycles    : captured v0, RUN edges elapsed (saturating)
//   dbg_state         : current FSM state
// -----------------------------------------------------------------------------
module mips_cpu_harness
   import mips_harness_pkg::*;
#(
   parameter int          DEPTH        = 64,
   parameter logic [31:0] BASE_ADDR    = MIPS_RESET_VECTOR,
   parameter int          RESET_CYCLES = 2,
   parameter int          MAX_CYCLES   = 1000,
   parameter int          BIG_ENDIAN   = 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     load_valid,
   output logic                     load_ready,
   input  logic [$clog2(DEPTH)-1:0] load_index,
   input  logic [31:0]              load_data,
   input  logic                     start,
   output logic                     cpu_reset,
   input  logic [31:0]              instr_address,
   output logic [31:0]              instr_readdata,
   input  logic                     active,
   input  logic [31:0]              register_v0,
   output logic                     done,
   output logic                     timeout,
   output logic [31:0]              result,
   output logic [31:0]              cycles,
   output state_t                   dbg_state
);

`ifdef MIPS_HARNESS_TIMEOUT_EN
   localparam bit WDOG_EN = 1'b1;
`else
   localparam bit WDOG_EN = 1'b0;
`endif

   state_t      r_state;
   state_t      w_next;
   logic [31:0] r_cycles;
   logic [31:0] r_result;
   logic [31:0] r_rst_cnt;
   logic        r_done;
   logic        r_timeout;

   logic [31:0] w_cycles_inc;
   logic        w_halt;
   logic        w_limit;
   logic        w_rst_last;
   logic        w_cpu_reset;
   logic        w_load_ready;
   logic        w_wr_en;

   assign w_cycles_inc = (r_cycles == 32'hFFFF_FFFF) ? r_cycles : r_cycles + 32'd1;
   assign w_halt       = (r_state == ST_RUN) && !active && (instr_address == 32'd0);
   // Compared against the post-increment count so the limiting edge itself
   // is counted; halt takes priority in the datapath below.
   assign w_limit      = WDOG_EN && (r_state == ST_RUN) &&
                         (w_cycles_inc >= 32'(MAX_CYCLES));
   assign w_rst_last   = (r_rst_cnt == 32'(RESET_CYCLES - 1));
   assign w_wr_en      = load_valid && w_load_ready;

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state logic
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE, ST_DONE: if (start)             w_next = ST_RESET_CPU;
         ST_RESET_CPU:     if (w_rst_last)        w_next = ST_RUN;
         ST_RUN:           if (w_halt || w_limit) w_next = ST_DONE;
         default:                                 w_next = ST_IDLE;
      endcase
   end

   // State-decoded outputs
   always_comb begin
      w_cpu_reset  = 1'b1;
      w_load_ready = 1'b0;
      case (r_state)
         ST_IDLE: w_load_ready = 1'b1;
         ST_RUN:  w_cpu_reset  = 1'b0;
         ST_DONE: w_load_ready = 1'b1;
         default: ;
      endcase
   end

   // Counters and capture registers
   always_ff @(posedge clk) begin
      if (reset) begin
         r_cycles  <= '0;
         r_result  <= '0;
         r_rst_cnt <= '0;
         r_done    <= 1'b0;
         r_timeout <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  r_cycles  <= '0;
                  r_result  <= '0;
                  r_rst_cnt <= '0;
                  r_done    <= 1'b0;
                  r_timeout <= 1'b0;
               end
            end
            ST_RESET_CPU: r_rst_cnt <= r_rst_cnt + 32'd1;
            ST_RUN: begin
               r_cycles <= w_cycles_inc;
               if (w_halt) begin
                  r_result <= register_v0;
                  r_done   <= 1'b1;
               end else if (w_limit) begin
                  r_result  <= register_v0;
                  r_done    <= 1'b1;
                  r_timeout <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   mips_harness_imem #(
      .DEPTH      (DEPTH),
      .BASE_ADDR  (BASE_ADDR),
      .BIG_ENDIAN (BIG_ENDIAN)
   ) u_imem (
      .clk      (clk),
      .wr_en    (w_wr_en),
      .wr_index (load_index),
      .wr_data  (load_data),
      .rd_addr  (instr_address),
      .rd_data  (instr_readdata)
   );

   assign load_ready = w_load_ready;
   assign cpu_reset  = w_cpu_reset;
   assign done       = r_done;
   assign timeout    = WDOG_EN ? r_timeout : 1'b0;
   assign result     = r_result;
   assign cycles     = r_cycles;
   assign dbg_state  = r_state;

endmodule

// File: tb/tb_mips_cpu_harness.sv
// -----------------------------------------------------------------------------
// tb_mips_cpu_harness
// Drives mips_cpu_harness (big-endian instance plus a little-endian instance
// for fetch-order checks). The bench plays the CPU: a small instruction-level
// MIPS model (j, addiu, blez, jr with delay slots) executes the loaded program
// from the bench's own copy of memory, and a raw driver produces halts at
// chosen RUN edges. Watchdog expectations follow MIPS_HARNESS_TIMEOUT_EN.
// -----------------------------------------------------------------------------
module tb_mips_cpu_harness;

   localparam int          DEPTH   = 64;
   localparam logic [31:0] BASE    = 32'hBFC0_0000;
   localparam int          RST_CYC = 2;
   localparam int          MAXC    = 50;
`ifdef MIPS_HARNESS_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset, load_valid, start, active;
   logic [5:0]  load_index;
   logic [31:0] load_data, instr_address, register_v0;
   logic        load_ready, cpu_reset, done, timeout;
   logic [31:0] instr_readdata, result, cycles;
   logic [1:0]  dbg_state;
   logic        le_load_ready, le_cpu_reset, le_done, le_timeout;
   logic [31:0] le_instr_readdata, le_result, le_cycles;
   logic [1:0]  le_dbg_state;

   int vectors     = 0;
   int miscompares = 0;
   logic [31:0] mdl_mem [DEPTH];
   logic [31:0] first_result, tmp_v0;

   always #5 clk = ~clk;

   mips_cpu_harness #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .RESET_CYCLES(RST_CYC),
                      .MAX_CYCLES(MAXC), .BIG_ENDIAN(1)) u_dut (
      .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(load_ready),
      .load_index(load_index), .load_data(load_data), .start(start),
      .cpu_reset(cpu_reset), .instr_address(instr_address),
      .instr_readdata(instr_readdata), .active(active), .register_v0(register_v0),
      .done(done), .timeout(timeout), .result(result), .cycles(cycles),
      .dbg_state(dbg_state));

   mips_cpu_harness #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .RESET_CYCLES(RST_CYC),
                      .MAX_CYCLES(MAXC), .BIG_ENDIAN(0)) u_dut_le (
      .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(le_load_ready),
      .load_index(load_index), .load_data(load_data), .start(start),
      .cpu_reset(le_cpu_reset), .instr_address(instr_address),
      .instr_readdata(le_instr_readdata), .active(active), .register_v0(register_v0),
      .done(le_done), .timeout(le_timeout), .result(le_result), .cycles(le_cycles),
      .dbg_state(le_dbg_state));

   initial begin
      #2_000_000;
      $display("FAIL global_time_limit: observed no finish, expected finish");
      $fatal(1, "time limit");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference fetch: byte offset from the base, window and alignment rules.
   function automatic logic [31:0] exp_fetch(input logic [31:0] a, input bit be);
      longint      off;
      logic [31:0] w, r;
      off = longint'(a) - longint'(BASE);
      if (off < 0 || off >= 4 * DEPTH || (a % 4) != 0) return 32'h0;
      w = mdl_mem[off / 4];
      if (!be) return w;
      for (int b = 0; b < 4; b++) r[8*b +: 8] = w[8*(3-b) +: 8];
      return r;
   endfunction

   task automatic load_word(input int idx, input logic [31:0] data);
      load_valid = 1'b1;
      load_index = 6'(idx);
      load_data  = data;
      chk("load_ready_idle", {31'b0, load_ready}, 32'd1);
      tick();
      load_valid = 1'b0;
      mdl_mem[idx] = data;
   endtask

   task automatic fetch_check(input logic [31:0] a);
      instr_address = a;
      #1;
      chk("fetch_be", instr_readdata, exp_fetch(a, 1'b1));
      chk("fetch_le", le_instr_readdata, exp_fetch(a, 1'b0));
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("start_clears_done", {31'b0, done}, 32'd0);
      chk("start_clears_timeout", {31'b0, timeout}, 32'd0);
      chk("start_clears_cycles", cycles, 32'd0);
      chk("start_clears_result", result, 32'd0);
      for (int i = 0; i < RST_CYC; i++) begin
         chk("cpu_reset_hold", {31'b0, cpu_reset}, 32'd1);
         tick();
      end
      chk("cpu_reset_release", {31'b0, cpu_reset}, 32'd0);
   endtask

   // Instruction-level CPU model running the loaded program.
   task automatic prog_run(input int reset_at, output logic [31:0] v0_out);
      logic [31:0] regs [32];
      logic [31:0] pc, npc, ins, tgt, simm;
      int edges, limit;
      bit halted, taken;
      foreach (regs[i]) regs[i] = 32'h0;
      regs[2] = $urandom;
      pc = BASE; npc = BASE + 32'd4; edges = 0; halted = 1'b0;
      limit = TO_EN ? MAXC : 120;
      instr_address = BASE; active = 1'b1; register_v0 = regs[2];
      v0_out = regs[2];
      do_start();
      while (!halted && edges < limit) begin
         register_v0 = regs[2];
         if (pc == 32'h0) begin
            instr_address = 32'h0; active = 1'b0; halted = 1'b1;
         end else begin
            instr_address = pc; active = 1'b1;
            #1;
            chk("run_fetch", instr_readdata, exp_fetch(pc, 1'b1));
            ins  = exp_fetch(pc, 1'b0);
            simm = {{16{ins[15]}}, ins[15:0]};
            taken = 1'b0; tgt = 32'h0;
            case (ins[31:26])
               6'h02: begin taken = 1'b1; tgt = {npc[31:28], ins[25:0], 2'b00}; end
               6'h09: if (ins[20:16] != 5'd0) regs[ins[20:16]] = regs[ins[25:21]] + simm;
               6'h06: if ($signed(regs[ins[25:21]]) <= 0) begin
                         taken = 1'b1; tgt = npc + (simm << 2);
                      end
               6'h00: if (ins[5:0] == 6'h08) begin taken = 1'b1; tgt = regs[ins[25:21]]; end
               default: ;
            endcase
            pc  = npc;
            npc = taken ? tgt : npc + 32'd4;
         end
         if (edges == 1) begin
            chk("load_ready_run", {31'b0, load_ready}, 32'd0);
            load_valid = 1'b1; load_index = 6'd20; load_data = ~mdl_mem[20];
            start = 1'b1;
         end
         if (reset_at > 0 && edges == reset_at) reset = 1'b1;
         tick();
         edges++;
         load_valid = 1'b0; start = 1'b0;
         if (reset) begin
            reset = 1'b0;
            chk("midrun_reset_cpu_reset", {31'b0, cpu_reset}, 32'd1);
            chk("midrun_reset_cycles", cycles, 32'd0);
            chk("midrun_reset_done", {31'b0, done}, 32'd0);
            chk("midrun_reset_load_ready", {31'b0, load_ready}, 32'd1);
            active = 1'b1; instr_address = BASE;
            return;
         end
         if (edges == 2 && !halted) chk("start_ignored_run", {31'b0, cpu_reset}, 32'd0);
      end
      if (halted) begin
         chk("halt_done", {31'b0, done}, 32'd1);
         chk("halt_timeout", {31'b0, timeout}, 32'd0);
         chk("halt_result", result, regs[2]);
         chk("halt_cycles", cycles, 32'(edges));
      end else if (TO_EN) begin
         chk("wdog_done", {31'b0, done}, 32'd1);
         chk("wdog_timeout", {31'b0, timeout}, 32'd1);
         chk("wdog_result", result, regs[2]);
         chk("wdog_cycles", cycles, 32'(MAXC));
      end else begin
         chk("hung_done", {31'b0, done}, 32'd0);
         chk("hung_timeout", {31'b0, timeout}, 32'd0);
         chk("hung_cpu_reset", {31'b0, cpu_reset}, 32'd0);
         chk("hung_cycles", cycles, 32'(edges));
         reset = 1'b1; tick(); reset = 1'b0;
      end
      v0_out = regs[2];
      active = 1'b1; instr_address = BASE;
   endtask

   // Raw CPU driver: halt presented on RUN edge number halt_at.
   task automatic raw_run(input int halt_at, input logic [31:0] v0);
      bit exp_to;
      int exp_cycles;
      exp_to     = TO_EN && (halt_at > MAXC);
      exp_cycles = exp_to ? MAXC : halt_at;
      active = 1'b1; instr_address = BASE;
      do_start();
      register_v0 = v0;
      for (int k = 1; k <= halt_at; k++) begin
         if (k == halt_at) begin active = 1'b0; instr_address = 32'h0; end
         tick();
         if (done === 1'b1) break;
      end
      chk("raw_done", {31'b0, done}, 32'd1);
      chk("raw_timeout", {31'b0, timeout}, {31'b0, exp_to});
      chk("raw_result", result, v0);
      chk("raw_cycles", cycles, 32'(exp_cycles));
      active = 1'b1; instr_address = BASE;
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; load_valid = 1'b0; load_index = '0; load_data = '0;
      instr_address = BASE; active = 1'b1; register_v0 = '0;
      tick(); tick();
      reset = 1'b0;
      chk("rst_cpu_reset", {31'b0, cpu_reset}, 32'd1);
      chk("rst_load_ready", {31'b0, load_ready}, 32'd1);
      chk("rst_done", {31'b0, done}, 32'd0);
      chk("rst_timeout", {31'b0, timeout}, 32'd0);
      chk("rst_result", result, 32'd0);
      chk("rst_cycles", cycles, 32'd0);

      for (int i = 0; i < DEPTH; i++) load_word(i, $urandom);
      for (int n = 0; n < 48; n++) begin
         case ($urandom_range(0, 3))
            0: fetch_check(BASE + 32'(4 * $urandom_range(0, DEPTH - 1)));
            1: fetch_check(BASE + 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(1, 3)));
            2: fetch_check(BASE - 32'(4 * $urandom_range(1, 1000)));
            default: fetch_check(BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 1000)));
         endcase
      end

      load_word(0, 32'h0BF0_0004);
      instr_address = 32'hBFC0_0000; #1;
      chk("fetch_word0_be", instr_readdata, 32'h0400_F00B);
      chk("fetch_word0_le", le_instr_readdata, 32'h0BF0_0004);
      instr_address = 32'hBFC0_0002; #1;
      chk("fetch_unaligned", instr_readdata, 32'h0);
      instr_address = 32'hBFC0_0100; #1;
      chk("fetch_past_end", instr_readdata, 32'h0);

      load_word(1, 32'h2421_FFFE);
      load_word(2, 32'h0000_0008);
      load_word(3, 32'h2402_0002);
      load_word(4, 32'h1820_FFFD);
      load_word(5, 32'h2400_0000);
      prog_run(0, first_result);
      chk("blez_result_is_2", result, 32'd2);
      chk("done_cpu_reset", {31'b0, cpu_reset}, 32'd1);
      chk("done_load_ready", {31'b0, load_ready}, 32'd1);
      fetch_check(BASE + 32'd80);

      prog_run(3, tmp_v0);
      prog_run(0, tmp_v0);
      chk("rerun_same_result", result, first_result);

      raw_run(MAXC, $urandom);
      raw_run(1, $urandom);
      for (int n = 0; n < 5; n++) raw_run($urandom_range(2, 90), $urandom);

      load_word(0, 32'h0BF0_0000);
      load_word(1, 32'h0000_0000);
      prog_run(0, tmp_v0);

      for (int n = 0; n < 16; n++)
         fetch_check(BASE + 32'(4 * $urandom_range(0, DEPTH - 1)));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
